multi_cycle_control_unit: RTL and testbench

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

---
 rtl/multi_cycle_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
// Control FSM for a multi-cycle RV32I datapath: sequences fetch, decode, execute,
// memory, and writeback, and drives the datapath steering signals from the current state.
module multi_cycle_control_unit #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_cond,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       retire,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_EX2 = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_PC4 = 3'd6, S_HALT = 3'd7
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       retire;
        logic       halted;
    } ctl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [1:0] ALU_CTRL_ADD   = 2'b00;
    localparam logic [1:0] ALU_CTRL_SUB   = 2'b01;
    localparam logic [1:0] ALU_CTRL_ARITH = 2'b10;
    localparam logic [1:0] ALU_CTRL_IMME  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_ALU    = 2'b10;

    state_t state_q, state_d;
    ctl_t   ctl;
    logic   mem_rdy;

    // Single-cycle memory configurations tie the handshake high.
    assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        unique case (state_q)
            S_IF: begin
                ctl.mem_read = 1'b1;
                ctl.ir_write = mem_rdy;
                if (mem_rdy) state_d = S_ID;
            end
            S_ID: begin
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_CTRL_ADD;
                if (opcode == OP_ECALL) begin
                    if (halt_cond) begin
                        state_d = S_HALT;
                    end else begin
                        ctl.alu_src_b = SRCB_FOUR;
                        ctl.pc_write  = 1'b1;
                        ctl.retire    = 1'b1;
                        state_d       = S_IF;
                    end
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                state_d = S_PC4;
                case (opcode)
                    OP_R: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = SRCB_REG;
                        ctl.alu_op    = ALU_CTRL_ARITH;
                        state_d       = S_WB;
                    end
                    OP_I: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = SRCB_IMM;
                        ctl.alu_op    = ALU_CTRL_IMME;
                        state_d       = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = SRCB_IMM;
                        ctl.alu_op    = ALU_CTRL_ADD;
                        state_d       = S_MEM;
                    end
                    OP_BRANCH: begin
                        ctl.alu_src_a = 1'b1;
                        ctl.alu_src_b = SRCB_REG;
                        ctl.alu_op    = ALU_CTRL_SUB;
                        if (bcond) begin
                            ctl.pc_write  = 1'b1;
                            ctl.pc_source = 1'b1;
                            ctl.retire    = 1'b1;
                            state_d       = S_IF;
                        end
                    end
                    OP_JAL: begin
                        ctl.alu_src_b = SRCB_FOUR;
                        ctl.reg_write = 1'b1;
                        ctl.wb_sel    = WB_ALU;
                        ctl.pc_write  = 1'b1;
                        ctl.pc_source = 1'b1;
                        ctl.retire    = 1'b1;
                        state_d       = S_IF;
                    end
                    OP_JALR: begin
                        ctl.alu_src_b = SRCB_FOUR;
                        ctl.reg_write = 1'b1;
                        ctl.wb_sel    = WB_ALU;
                        state_d       = S_EX2;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                // Target comes from the A latched in ID, so rd == rs1 cannot corrupt it.
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_CTRL_ADD;
                ctl.pc_write  = 1'b1;
                ctl.retire    = 1'b1;
                state_d       = S_IF;
            end
            S_MEM: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_read  = (opcode == OP_LOAD);
                ctl.mem_write = (opcode != OP_LOAD);
                if (mem_rdy) state_d = (opcode == OP_LOAD) ? S_WB : S_PC4;
            end
            S_WB: begin
                ctl.reg_write = 1'b1;
                ctl.wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
                state_d       = S_PC4;
            end
            S_PC4: begin
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_CTRL_ADD;
                ctl.pc_write  = 1'b1;
                ctl.retire    = 1'b1;
                state_d       = S_IF;
            end
            S_HALT: begin
                ctl.halted = 1'b1;
            end
            default: state_d = S_IF;
        endcase
        if (reset) begin
            ctl     = '0;
            state_d = S_IF;
        end
    end

    assign {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, pc_source,
            alu_src_a, alu_src_b, alu_op, wb_sel, retire, halted} = ctl;
    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: walks each instruction class cycle by
// cycle and compares the state and the full control word against hand-derived values.
module tb_multi_cycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond, halt_cond, mem_ready;

    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, pc_source, alu_src_a;
    logic [1:0] alu_src_b, alu_op, wb_sel;
    logic [2:0] state;
    logic       retire, halted;

    logic       d2_pc_write, d2_i_or_d, d2_mem_read, d2_mem_write, d2_ir_write;
    logic       d2_reg_write, d2_pc_source, d2_alu_src_a, d2_retire, d2_halted;
    logic [1:0] d2_alu_src_b, d2_alu_op, d2_wb_sel;
    logic [2:0] d2_state;

    multi_cycle_control_unit #(.USE_MEM_READY(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
        .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .wb_sel(wb_sel), .state(state), .retire(retire), .halted(halted)
    );

    // Second copy with the memory handshake ignored.
    multi_cycle_control_unit #(.USE_MEM_READY(0)) dut_nr (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
        .mem_ready(mem_ready), .pc_write(d2_pc_write), .i_or_d(d2_i_or_d),
        .mem_read(d2_mem_read), .mem_write(d2_mem_write), .ir_write(d2_ir_write),
        .reg_write(d2_reg_write), .pc_source(d2_pc_source), .alu_src_a(d2_alu_src_a),
        .alu_src_b(d2_alu_src_b), .alu_op(d2_alu_op), .wb_sel(d2_wb_sel),
        .state(d2_state), .retire(d2_retire), .halted(d2_halted)
    );

    always #5 clk = ~clk;

    // Control word: pw iod mr mw irw rw ps asa | asb(2) aop(2) wb(2) | ret hlt
    logic [15:0] cw;
    assign cw = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, pc_source,
                 alu_src_a, alu_src_b, alu_op, wb_sel, retire, halted};

    localparam logic [15:0] C_ZERO    = 16'b0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [15:0] C_IF      = 16'b0_0_1_0_1_0_0_0_00_00_00_0_0;
    localparam logic [15:0] C_IF_WAIT = 16'b0_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [15:0] C_ID      = 16'b0_0_0_0_0_0_0_0_10_00_00_0_0;
    localparam logic [15:0] C_ID_ECL  = 16'b1_0_0_0_0_0_0_0_01_00_00_1_0;
    localparam logic [15:0] C_EX_R    = 16'b0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [15:0] C_EX_I    = 16'b0_0_0_0_0_0_0_1_10_11_00_0_0;
    localparam logic [15:0] C_EX_LS   = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [15:0] C_EX_BT   = 16'b1_0_0_0_0_0_1_1_00_01_00_1_0;
    localparam logic [15:0] C_EX_BN   = 16'b0_0_0_0_0_0_0_1_00_01_00_0_0;
    localparam logic [15:0] C_EX_JAL  = 16'b1_0_0_0_0_1_1_0_01_00_10_1_0;
    localparam logic [15:0] C_EX_JALR = 16'b0_0_0_0_0_1_0_0_01_00_10_0_0;
    localparam logic [15:0] C_EX2     = 16'b1_0_0_0_0_0_0_1_10_00_00_1_0;
    localparam logic [15:0] C_MEM_LD  = 16'b0_1_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [15:0] C_MEM_ST  = 16'b0_1_0_1_0_0_0_0_00_00_00_0_0;
    localparam logic [15:0] C_WB_ALU  = 16'b0_0_0_0_0_1_0_0_00_00_00_0_0;
    localparam logic [15:0] C_WB_LD   = 16'b0_0_0_0_0_1_0_0_00_00_01_0_0;
    localparam logic [15:0] C_PC4     = 16'b1_0_0_0_0_0_0_0_01_00_00_1_0;
    localparam logic [15:0] C_HALT    = 16'b0_0_0_0_0_0_0_0_00_00_00_0_1;

    localparam logic [2:0] IF = 3'd0, ID = 3'd1, EX = 3'd2, EX2 = 3'd3,
                           MEM = 3'd4, WB = 3'd5, PC4 = 3'd6, HALT = 3'd7;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are set #1 after a rising edge; outputs are compared #3 after it.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [15:0] exp);
        #2;
        check({tag, ".state"}, {13'd0, state}, {13'd0, st});
        check({tag, ".ctl"}, cw, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 7'b0110011; bcond = 1'b0; halt_cond = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc("rst0", IF, C_ZERO);
        cyc("rst1", IF, C_ZERO);
        reset = 1'b0;

        // Fetch stall: the handshake-less copy proceeds regardless.
        mem_ready = 1'b0;
        cyc("if_wait", IF, C_IF_WAIT);
        check("nr_state", {13'd0, d2_state}, {13'd0, ID});
        mem_ready = 1'b1;

        // ADD
        opcode = 7'b0110011;
        cyc("add.if", IF, C_IF); cyc("add.id", ID, C_ID); cyc("add.ex", EX, C_EX_R);
        cyc("add.wb", WB, C_WB_ALU); cyc("add.pc4", PC4, C_PC4);

        // ADDI
        opcode = 7'b0010011;
        cyc("addi.if", IF, C_IF); cyc("addi.id", ID, C_ID); cyc("addi.ex", EX, C_EX_I);
        cyc("addi.wb", WB, C_WB_ALU); cyc("addi.pc4", PC4, C_PC4);

        // LW with three wait cycles in MEM
        opcode = 7'b0000011;
        cyc("lw.if", IF, C_IF); cyc("lw.id", ID, C_ID); cyc("lw.ex", EX, C_EX_LS);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw.mem_wait", MEM, C_MEM_LD);
        mem_ready = 1'b1;
        cyc("lw.mem", MEM, C_MEM_LD); cyc("lw.wb", WB, C_WB_LD); cyc("lw.pc4", PC4, C_PC4);

        // SW
        opcode = 7'b0100011;
        cyc("sw.if", IF, C_IF); cyc("sw.id", ID, C_ID); cyc("sw.ex", EX, C_EX_LS);
        cyc("sw.mem", MEM, C_MEM_ST); cyc("sw.pc4", PC4, C_PC4);

        // BEQ taken then not taken
        opcode = 7'b1100011; bcond = 1'b1;
        cyc("beqt.if", IF, C_IF); cyc("beqt.id", ID, C_ID); cyc("beqt.ex", EX, C_EX_BT);
        bcond = 1'b0;
        cyc("beqn.if", IF, C_IF); cyc("beqn.id", ID, C_ID); cyc("beqn.ex", EX, C_EX_BN);
        cyc("beqn.pc4", PC4, C_PC4);

        // JAL, JALR
        opcode = 7'b1101111;
        cyc("jal.if", IF, C_IF); cyc("jal.id", ID, C_ID); cyc("jal.ex", EX, C_EX_JAL);
        opcode = 7'b1100111;
        cyc("jalr.if", IF, C_IF); cyc("jalr.id", ID, C_ID); cyc("jalr.ex", EX, C_EX_JALR);
        cyc("jalr.ex2", EX2, C_EX2);

        // Unrecognised opcode behaves as a NOP
        opcode = 7'b0000000;
        cyc("nop.if", IF, C_IF); cyc("nop.id", ID, C_ID); cyc("nop.ex", EX, C_ZERO);
        cyc("nop.pc4", PC4, C_PC4);

        // ECALL without halt
        opcode = 7'b1110011; halt_cond = 1'b0;
        cyc("ecall.if", IF, C_IF); cyc("ecall.id", ID, C_ID_ECL);

        // Reset during a MEM wait
        opcode = 7'b0000011;
        cyc("lwr.if", IF, C_IF); cyc("lwr.id", ID, C_ID); cyc("lwr.ex", EX, C_EX_LS);
        mem_ready = 1'b0;
        cyc("lwr.mem", MEM, C_MEM_LD);
        reset = 1'b1;
        cyc("lwr.rst", MEM, C_ZERO);
        reset = 1'b0; mem_ready = 1'b1;

        // ECALL with halt: absorbing, then reset recovers
        opcode = 7'b1110011; halt_cond = 1'b1;
        cyc("halt.if", IF, C_IF); cyc("halt.id", ID, C_ID);
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            cyc("halt.hold", HALT, C_HALT);
        end
        mem_ready = 1'b1;
        reset = 1'b1;
        cyc("halt.rst", HALT, C_ZERO);
        reset = 1'b0; halt_cond = 1'b0;
        cyc("halt.after", IF, C_IF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
